// File: rtl/fetch_pkg.sv
// fetch_pkg: decoder field positions, HALT opcode and fetch state encoding
package fetch_pkg;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int RD_BIT  = 26;
    localparam int RS1_BIT = 25;
    localparam int RS2_BIT = 24;
    localparam logic [4:0] OP_HALT = 5'b00000;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {instr, pc} FIFO whose head registers feed the decoder directly
module fetch_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [PC_W-1:0]    push_pc,
    output logic [1:0]         count,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PC_W-1:0]    head_pc
);
    logic [INSTR_W-1:0] tail_instr;
    logic [PC_W-1:0]    tail_pc;
    logic               load_head;
    // a push lands in the head slot whenever the head is (or is becoming) empty
    assign load_head = push && (count == 2'd0 || (count == 2'd1 && pop));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (load_head) begin
                head_instr <= push_instr;
                head_pc    <= push_pc;
            end else if (pop) begin
                head_instr <= tail_instr;
                head_pc    <= tail_pc;
            end
            if (push && !load_head) begin
                tail_instr <= push_instr;
                tail_pc    <= push_pc;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-cycle ROM issue, 2-entry decode queue and branch redirect
// FETCH_HALT_EN adds HALT-opcode detection with a RUN/DRAIN/HALTED state machine.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic [4:0]         dec_opcode,
    output logic               dec_rd_type,
    output logic               dec_rs1_type,
    output logic               dec_rs2_type,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               halted
);
    logic [PC_W-1:0] pc, inflight_pc;
    logic            inflight, pop, push, br, stop, halt_push;
    logic [1:0]      count;
    logic [2:0]      occ;

    assign dec_valid    = count != 2'd0;
    assign pop          = dec_valid && dec_ready;
    assign push         = inflight;
    assign occ          = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    // rst_n gating keeps the ROM idle while reset is held
    assign imem_en      = rst_n && !stop && !br && occ <= 3'd1;
    assign imem_addr    = pc;
    assign dec_opcode   = dec_instr[OP_MSB:OP_LSB];
    assign dec_rd_type  = dec_instr[RD_BIT];
    assign dec_rs1_type = dec_instr[RS1_BIT];
    assign dec_rs2_type = dec_instr[RS2_BIT];

`ifdef FETCH_HALT_EN
    state_t state;
    assign halt_push = push && imem_rdata[OP_MSB:OP_LSB] == OP_HALT;
    assign stop      = state != RUN;
    assign halted    = state == HALTED;
    assign br        = br_taken && state != HALTED;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else if (br)
            state <= RUN;
        else if (state == RUN && halt_push)
            state <= DRAIN;
        else if (state == DRAIN && (count == 2'd0 || (count == 2'd1 && pop)))
            state <= HALTED;
    end
`else
    assign halt_push = 1'b0;
    assign stop      = 1'b0;
    assign halted    = 1'b0;
    assign br        = br_taken;
`endif

    // a fetch issued alongside a HALT push is killed so nothing follows HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            pc          <= br ? br_target : imem_en ? pc + PC_W'(1) : pc;
            inflight    <= imem_en && !halt_push;
            inflight_pc <= pc;
        end
    end

    fetch_queue #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (br),
        .push_instr(imem_rdata),
        .push_pc   (inflight_pc),
        .count     (count),
        .head_instr(dec_instr),
        .head_pc   (dec_pc)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a synchronous ROM model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [15:0] dec_pc;
    logic [4:0]  dec_opcode;
    logic        dec_rd_type, dec_rs1_type, dec_rs2_type;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic        halted;
    logic [31:0] rom [0:255];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr[7:0]];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
        .dec_rd_type(dec_rd_type), .dec_rs1_type(dec_rs1_type), .dec_rs2_type(dec_rs2_type),
        .br_taken(br_taken), .br_target(br_target), .halted(halted)
    );

    // word i: opcode i%31+1 (never HALT), type bits i[2:0]
    function automatic logic [31:0] word(int i);
        return {5'(i % 31 + 1), 3'(i), 16'hC0DE, 8'(i)};
    endfunction

    // assert reset mid-cycle, release one edge later; returns inside C0
    task automatic start;
        rst_n = 1'b0; br_taken = 1'b0; br_target = '0; dec_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic next;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (imem_en !== 1'b0 || imem_addr !== 16'h0 || halted !== 1'b0) begin
            fails++; $display("FAIL reset_imem: en=%b addr=%h halted=%b want 0 0000 0", imem_en, imem_addr, halted);
        end
        tests++;
        if (dec_valid !== 1'b0 || dec_instr !== 32'h0 || dec_pc !== 16'h0) begin
            fails++; $display("FAIL reset_dec: valid=%b instr=%h pc=%h want 0 0 0", dec_valid, dec_instr, dec_pc);
        end
        tests++;
        if ({dec_opcode, dec_rd_type, dec_rs1_type, dec_rs2_type} !== 8'h00) begin
            fails++; $display("FAIL reset_fields: got %h want 00", {dec_opcode, dec_rd_type, dec_rs1_type, dec_rs2_type});
        end
        dec_ready = 1'b1;
        next(); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next();
            if (c == 3) begin
                rst_n = 1'b0; #1;
                tests++;
                if (dec_valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 16'h0 || dec_instr !== 32'h0) begin
                    fails++; $display("FAIL async_reset: valid=%b en=%b addr=%h instr=%h want 0 0 0000 0", dec_valid, imem_en, imem_addr, dec_instr);
                end
            end else begin
                @(negedge clk);
                if (c == 0) begin
                    tests++;
                    if (imem_en !== 1'b1 || imem_addr !== 16'h0) begin
                        fails++; $display("FAIL reset_c0: en=%b addr=%h want 1 0000", imem_en, imem_addr);
                    end
                end
            end
        end
        next(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next();
            @(negedge clk);
        end
        tests++;
        if (dec_valid !== 1'b1 || dec_instr !== word(0) || dec_pc !== 16'h0) begin
            fails++; $display("FAIL reset_restart: valid=%b instr=%h pc=%h want 1 %h 0000", dec_valid, dec_instr, dec_pc, word(0));
        end
    endtask

    task automatic test_stream;
        start();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next();
            @(negedge clk);
            if (c < 4) begin
                tests++;
                if (imem_en !== 1'b1 || imem_addr !== 16'(c)) begin
                    fails++; $display("FAIL stream_issue c%0d: en=%b addr=%h want 1 %h", c, imem_en, imem_addr, 16'(c));
                end
            end
            if (c >= 2) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_instr !== word(c - 2) || dec_pc !== 16'(c - 2)) begin
                    fails++; $display("FAIL stream_dec c%0d: valid=%b instr=%h pc=%h want 1 %h %h", c, dec_valid, dec_instr, dec_pc, word(c - 2), 16'(c - 2));
                end
                tests++;
                if ({dec_opcode, dec_rd_type, dec_rs1_type, dec_rs2_type} !== {5'(c - 1), 3'(c - 2)}) begin
                    fails++; $display("FAIL stream_fields c%0d: got %h want %h", c, {dec_opcode, dec_rd_type, dec_rs1_type, dec_rs2_type}, {5'(c - 1), 3'(c - 2)});
                end
            end
        end
    endtask

    task automatic test_stall;
        start();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next();
            dec_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                tests++;
                if (imem_en !== 1'b0 || dec_valid !== 1'b1 || dec_instr !== word(1)) begin
                    fails++; $display("FAIL stall_hold c%0d: en=%b valid=%b instr=%h want 0 1 %h", c, imem_en, dec_valid, dec_instr, word(1));
                end
            end
            if (c == 7) begin
                tests++;
                if (imem_en !== 1'b1 || imem_addr !== 16'h3 || dec_instr !== word(1)) begin
                    fails++; $display("FAIL stall_release: en=%b addr=%h instr=%h want 1 0003 %h", imem_en, imem_addr, dec_instr, word(1));
                end
            end
            if (c >= 8) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_instr !== word(c - 6) || dec_pc !== 16'(c - 6)) begin
                    fails++; $display("FAIL stall_order c%0d: valid=%b instr=%h pc=%h want 1 %h %h", c, dec_valid, dec_instr, dec_pc, word(c - 6), 16'(c - 6));
                end
            end
        end
    endtask

    // ready_early=0: queue full at the branch; ready_early=1: branch coincides with a pop
    task automatic test_branch(input bit ready_early);
        start();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) next();
            dec_ready = ready_early || c >= 5;
            br_taken = c == 4;
            br_target = 16'h0040;
            @(negedge clk);
            if (c == 4) begin
                tests++;
                if (imem_en !== 1'b0 || dec_valid !== 1'b1 || dec_instr !== word(ready_early ? 2 : 0)) begin
                    fails++; $display("FAIL br%0d_T: en=%b valid=%b instr=%h want 0 1 %h", ready_early, imem_en, dec_valid, dec_instr, word(ready_early ? 2 : 0));
                end
            end
            if (c == 5) begin
                tests++;
                if (dec_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 16'h0040) begin
                    fails++; $display("FAIL br%0d_T1: valid=%b en=%b addr=%h want 0 1 0040", ready_early, dec_valid, imem_en, imem_addr);
                end
            end
            if (c == 6) begin
                tests++;
                if (dec_valid !== 1'b0) begin
                    fails++; $display("FAIL br%0d_T2: valid=%b want 0", ready_early, dec_valid);
                end
            end
            if (c >= 7) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_pc !== 16'(c + 57) || dec_instr !== word(c + 57)) begin
                    fails++; $display("FAIL br%0d_target c%0d: valid=%b pc=%h instr=%h want 1 %h %h", ready_early, c, dec_valid, dec_pc, dec_instr, 16'(c + 57), word(c + 57));
                end
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_wrap;
        start();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next();
            br_taken = c == 2;
            br_target = 16'hFFFF;
            @(negedge clk);
            if (c == 3 || c == 4) begin
                tests++;
                if (imem_en !== 1'b1 || imem_addr !== (c == 3 ? 16'hFFFF : 16'h0000)) begin
                    fails++; $display("FAIL wrap_issue c%0d: en=%b addr=%h", c, imem_en, imem_addr);
                end
            end
            if (c == 5 || c == 6) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_pc !== (c == 5 ? 16'hFFFF : 16'h0000) || dec_instr !== word(c == 5 ? 255 : 0)) begin
                    fails++; $display("FAIL wrap_dec c%0d: valid=%b pc=%h instr=%h", c, dec_valid, dec_pc, dec_instr);
                end
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_halt;
        rom[2] = 32'h0712_3456;
        start();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next();
            br_taken = c == 6;
            br_target = 16'h0040;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_instr !== rom[c - 2] || halted !== 1'b0) begin
                    fails++; $display("FAIL halt_words c%0d: valid=%b instr=%h halted=%b want 1 %h 0", c, dec_valid, dec_instr, halted, rom[c - 2]);
                end
            end
`ifdef FETCH_HALT_EN
            if (c >= 4) begin
                tests++;
                if (imem_en !== 1'b0) begin
                    fails++; $display("FAIL halt_issue c%0d: en=%b want 0", c, imem_en);
                end
            end
            if (c >= 5) begin
                tests++;
                if (halted !== 1'b1 || dec_valid !== 1'b0) begin
                    fails++; $display("FAIL halt_state c%0d: halted=%b valid=%b want 1 0", c, halted, dec_valid);
                end
            end
`else
            if (c == 4) begin
                tests++;
                if (imem_en !== 1'b1 || imem_addr !== 16'h4 || dec_opcode !== 5'b00000) begin
                    fails++; $display("FAIL nohalt_issue: en=%b addr=%h op=%b want 1 0004 00000", imem_en, imem_addr, dec_opcode);
                end
            end
            if (c == 5) begin
                tests++;
                if (dec_valid !== 1'b1 || dec_instr !== word(3) || halted !== 1'b0) begin
                    fails++; $display("FAIL nohalt_next: valid=%b instr=%h halted=%b want 1 %h 0", dec_valid, dec_instr, halted, word(3));
                end
            end
`endif
        end
        br_taken = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = word(i);
        test_reset();
        test_stream();
        test_stall();
        test_branch(1'b0);
        test_branch(1'b1);
        test_wrap();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the SIMD AES processor, directly upstream of the instruction decoder. Holds the PC, drives a synchronous instruction ROM with one-cycle read latency, buffers returned words in a 2-entry queue, and presents instruction, PC, and pre-extracted decoder fields (opcode, rd/rs1/rs2 type bits) under a valid/ready handshake. Handles branch redirect with flush of buffered and in-flight words.

## Interface
- `INSTR_W`, 32, instruction word width.
- `PC_W`, 16, PC width; word-addressed.
- `RESET_PC`, 0, PC value loaded at reset.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_en` out 1: ROM read enable.
- `imem_addr` out PC_W: ROM address, valid when `imem_en`=1.
- `imem_rdata` in INSTR_W: ROM data, valid the cycle after `imem_en`=1.
- `dec_valid` out 1: queue head valid.
- `dec_ready` in 1: decoder accepts head this cycle.
- `dec_instr` out INSTR_W: head instruction word.
- `dec_pc` out PC_W: address of head instruction.
- `dec_opcode` out 5: instruction bits [31:27].
- `dec_rd_type`, `dec_rs1_type`, `dec_rs2_type` out 1 each: bits [26], [25], [24] (1 = vector register).
- `br_taken` in 1: redirect request from execute.
- `br_target` in PC_W: redirect address.
- `halted` out 1: fetch stopped (only with FETCH_HALT_EN).

## Operation
- State: `pc`, `inflight` (1 bit, ROM read outstanding), 2-entry queue of {instr, pc}, `count` 0..2.
- Issue rule: `imem_en`=1 when not halting and `count + inflight - pop <= 1`, where pop = `dec_valid & dec_ready`. On issue, `imem_addr`=`pc` and `pc` <= `pc`+1. Wraps from 2^PC_W-1 to 0.
- Response: when `inflight`=1, `imem_rdata` is pushed with its address. The issue rule guarantees no overflow.
- Output: `dec_*` come straight from the queue head registers, with no combinational path from `imem_rdata`. The field outputs are slices of `dec_instr`.
- `dec_ready` is ignored while `dec_valid`=0. The head is held stable while `dec_valid`=1 and `dec_ready`=0.
- Redirect, with `br_taken`=1 in cycle T:
  - Queue cleared at the end of T. `dec_valid`=0 in T+1.
  - Any response arriving in T+1 from an issue in T is discarded.
  - `imem_en`=0 in T.
  - `pc` <= `br_target`. First target fetch issues in T+1.
- Simultaneous `br_taken` and pop: redirect wins, queue cleared.
- Simultaneous push and pop with `count`=2 cannot occur, by the issue rule.

## Timing
- Reset values: `imem_en`=0, `imem_addr`=RESET_PC, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, all field outputs 0, `halted`=0, `pc`=RESET_PC, `inflight`=0, `count`=0.
- First cycle after reset release (C0): `imem_en`=1, `imem_addr`=RESET_PC.
- Data returns in C1. `dec_valid`=1 in C2. Issue-to-decode latency is 2 cycles.
- Steady state with `dec_ready`=1: one instruction per cycle.
- Redirect penalty: target instruction at `dec_valid` in T+3.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous). The in-flight response is dropped.

## Configuration
- `FETCH_HALT_EN` defined:
  - Opcode 5'b00000 is HALT.
  - When a HALT word is pushed, issuing stops, and a response in flight behind it is discarded.
  - State goes RUN → DRAIN. HALT is still delivered to the decoder.
  - DRAIN → HALTED when the queue empties. `halted`=1 in HALTED.
  - HALTED exits only on reset.
  - `br_taken` in DRAIN performs a normal redirect and returns to RUN. `br_taken` in HALTED is ignored.
- `FETCH_HALT_EN` undefined: no halt detection, and `halted` is tied to 0. Opcode 00000 is fetched like any other word.

## Structure
- `fetch_pkg`: opcode field LSB/MSB constants, type-bit positions, `OP_HALT` constant, state enum {RUN, DRAIN, HALTED}.
- Sub-module `fetch_queue`: 2-entry FIFO of {instr, pc} with push, pop, flush, count, and head outputs. The flush input takes priority over push/pop.

## Test plan
- Reset release with ROM[0..3]=A,B,C,D and `dec_ready`=1: `imem_addr` reads 0,1,2,3 in C0..C3, and `dec_instr` reads A,B,C,D in C2..C5 with no gaps.
- `dec_ready`=0 for cycles 3..6: `count` reaches 2, `imem_en` drops, and head B holds stable. On release, order stays B,C,D with no loss or duplication.
- `br_taken`=1 with `br_target`=0x40 in cycle 4 while the queue is full: `dec_valid`=0 in cycle 5, `imem_addr`=0x40 in cycle 5, `dec_pc`=0x40 in cycle 7, and no pre-branch word appears after cycle 4.
- `br_taken` in the same cycle as a pop: queue flushed and target fetched next, as in the previous case.
- PC wrap: with PC_W=4 and `br_target`=0xF, consecutive `dec_pc` reads 0xF then 0x0.
- FETCH_HALT_EN with ROM[2]=opcode 00000: `dec_instr` shows words 0,1,2 only, `halted`=1 the cycle after word 2 is accepted, and `imem_en` stays 0 afterwards. A later `br_taken` has no effect.
